serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Parametrised bit-serial subtractor, the sequential successor to the single-bit half/full subtractor cell. It computes DIFF = A − B − BIN over WIDTH clock cycles, LSB first, using one full-subtractor slice and a registered borrow. A start/busy/done handshake lets a controller launch operands and collect the result. Results include borrow-out and signed overflow, so it serves as the compact subtract unit for area-constrained datapaths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.
CW, max(1,$clog2(WIDTH)), bit-counter width; derived, not overridden.

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous, active-high reset
start  input   1      launch request; sampled only in IDLE
bin    input   1      borrow-in, captured with operands (chaining)
a      input   WIDTH  minuend, captured on accepted start
b      input   WIDTH  subtrahend, captured on accepted start
busy   output  1      high while bits are being processed (SHIFT)
done   output  1      one-cycle pulse; diff/bout/ovf valid
diff   output  WIDTH  a − b − bin, modulo 2^WIDTH
bout   output  1      final borrow-out (unsigned a < b+bin)
ovf    output  1      signed two's-complement overflow

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; shift regs, borrow reg, counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge k -> capture a, b into shift regs; borrow reg <= bin; latch a[WIDTH-1], b[WIDTH-1] as sign bits; counter <= 0; state -> SHIFT. start=0 -> stay. Outputs hold the previous result.
- SHIFT (busy=1): each edge, on LSBs a0, b0 and borrow br:
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the result register from the MSB side; a and b shift right; counter++.
  - When counter == WIDTH−1, that edge processes the last bit; state -> DONE.
- DONE: done=1 for exactly one cycle; busy=0. diff = assembled result; bout = final br; ovf = (signA != signB) && (diff[WIDTH-1] != signA). Next edge -> IDLE unconditionally.
- Latency: start sampled at edge k; busy high from k+1 through k+WIDTH; done high in the cycle after edge k+WIDTH. Back-to-back throughput is one operation per WIDTH+2 cycles.
- diff, bout and ovf are registered. They change only on the DONE-entry edge or on reset, and are stable from done until the next DONE.
- start during SHIFT or DONE is ignored, with no queuing. a, b and bin are don't-care outside the accepting IDLE edge.
- WIDTH=1: single SHIFT cycle. With bin=0, the block behaves as a registered half subtractor (diff=a^b, bout=~a&b).
- Reset asserted mid-SHIFT/DONE aborts immediately: all outputs go to 0 and no done pulse is issued. The first start after release behaves normally.
- Chaining: a higher slice's bin is the lower slice's bout. No combinational path from any input to any output.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start 1 cycle -> busy high 8 cycles; done pulse 8 cycles after start; diff=0x02, bout=0, ovf=0.
- WIDTH=8, a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
- WIDTH=8, a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0. Two chained instances (16-bit), 0x0100−0x0001 -> low 0xFF, high 0x00, final bout=0.
- WIDTH=8: hold start=1 continuously with a changing each cycle -> only the operands at accepting IDLE edges are used; exactly one done per WIDTH+2 cycles; results match the captured values.
- WIDTH=8: assert rst at cycle 4 of SHIFT -> busy, done, diff, bout, ovf = 0 immediately (asynchronously). No done pulse follows. Next op 0x10−0x01 -> diff=0x0F.
- WIDTH=1: exhaustive a,b,bin ∈ {0,1} -> diff and bout match the full-subtractor truth table. With bin=0, (1,1)->0/0, (0,1)->1/1, (1,0)->1/0, (0,0)->0/0. done is one cycle after start.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor. Computes diff = a - b - bin over WIDTH clock cycles,
// least significant bit first, using a single full-subtractor slice and a
// registered borrow. A start/busy/done handshake launches an operation and
// reports its result.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset
//   start  : launch request, sampled only while idle
//   bin    : borrow-in, captured together with the operands
//   a      : minuend, captured on an accepted start
//   b      : subtrahend, captured on an accepted start
//   busy   : high while operand bits are being processed
//   done   : one-cycle pulse; diff/bout/ovf hold the new result
//   diff   : a - b - bin, modulo 2^WIDTH (registered)
//   bout   : final borrow-out, set when unsigned a < b + bin (registered)
//   ovf    : signed two's-complement overflow of the difference (registered)
//
// Chaining: feed a lower slice's bout into the next slice's bin and start the
// higher slice once the lower one reports done. Every output is driven from a
// register or from decoded state, so there is no combinational input-to-output
// path.
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter  int WIDTH = 8,
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_nxt;
   logic             br;
   logic             sign_a;
   logic             sign_b;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             slice_d;
   logic             slice_br;

   // One full-subtractor bit: returns {difference, borrow-out}.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
      logic [1:0] r;
      r[1] = x ^ y ^ bi;
      r[0] = (~x & y) | (~(x ^ y) & bi);
      return r;
   endfunction

   // Signed overflow of x - y: only possible when the operand signs differ,
   // and flagged when the result sign disagrees with the minuend sign.
   function automatic logic sub_ovf(input logic sx, input logic sy, input logic sd);
      return (sx != sy) && (sd != sx);
   endfunction

   assign {slice_d, slice_br} = full_sub(a_sr[0], b_sr[0], br);

   // New difference bit enters from the MSB side; after WIDTH shifts the
   // first (LSB) result bit has walked down to bit 0.
   assign res_nxt  = (res_sr >> 1) | (WIDTH'(slice_d) << (WIDTH - 1));
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // ---- control: state register -----------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- control: next state and handshake decode ------------------------
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---- datapath: operand capture, bit-serial shift, result registers ---
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  res_sr <= '0;
                  br     <= bin;
                  sign_a <= a[WIDTH-1];
                  sign_b <= b[WIDTH-1];
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_nxt;
               br     <= slice_br;
               cnt    <= cnt + 1'b1;
               // Published results only move on the edge that enters DONE,
               // so they stay stable between consecutive done pulses.
               if (last_bit) begin
                  diff <= res_nxt;
                  bout <= slice_br;
                  ovf  <= sub_ovf(sign_a, sign_b, res_nxt[WIDTH-1]);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor. Instantiates a WIDTH=8 unit, a
// chained pair of WIDTH=8 units forming a 16-bit subtractor, and a WIDTH=1
// unit. Expected results are computed from integer arithmetic and queued when
// an operation is launched, then popped when the unit reports done.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // main 8-bit unit
   logic         m_start = 1'b0, m_bin = 1'b0;
   logic [W-1:0] m_a = '0, m_b = '0;
   logic         m_busy, m_done, m_bout, m_ovf;
   logic [W-1:0] m_diff;

   // chained pair: low slice borrow feeds high slice
   logic         l_start = 1'b0, l_bin = 1'b0;
   logic [W-1:0] l_a = '0, l_b = '0;
   logic         l_busy, l_done, l_bout, l_ovf;
   logic [W-1:0] l_diff;
   logic         h_start = 1'b0;
   logic [W-1:0] h_a = '0, h_b = '0;
   logic         h_busy, h_done, h_bout, h_ovf;
   logic [W-1:0] h_diff;

   // 1-bit unit
   logic         w_start = 1'b0, w_bin = 1'b0;
   logic [0:0]   w_a = '0, w_b = '0;
   logic         w_busy, w_done, w_bout, w_ovf;
   logic [0:0]   w_diff;

   serial_subtractor #(.WIDTH(W)) u_main (
      .clk(clk), .rst(rst), .start(m_start), .bin(m_bin), .a(m_a), .b(m_b),
      .busy(m_busy), .done(m_done), .diff(m_diff), .bout(m_bout), .ovf(m_ovf));

   serial_subtractor #(.WIDTH(W)) u_lo (
      .clk(clk), .rst(rst), .start(l_start), .bin(l_bin), .a(l_a), .b(l_b),
      .busy(l_busy), .done(l_done), .diff(l_diff), .bout(l_bout), .ovf(l_ovf));

   serial_subtractor #(.WIDTH(W)) u_hi (
      .clk(clk), .rst(rst), .start(h_start), .bin(l_bout), .a(h_a), .b(h_b),
      .busy(h_busy), .done(h_done), .diff(h_diff), .bout(h_bout), .ovf(h_ovf));

   serial_subtractor #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .start(w_start), .bin(w_bin), .a(w_a), .b(w_b),
      .busy(w_busy), .done(w_done), .diff(w_diff), .bout(w_bout), .ovf(w_ovf));

   typedef struct packed {
      logic [15:0] diff;
      logic        bout;
      logic        ovf;
   } exp_t;

   exp_t sb_main[$];
   exp_t sb_chain[$];
   exp_t sb_w1[$];

   int errors = 0;
   int checks = 0;

   function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y, input logic bi);
      int   r;
      exp_t e;
      r      = int'(x) - int'(y) - int'(bi);
      e.diff = {8'h00, r[7:0]};
      e.bout = (r < 0);
      e.ovf  = (x[7] != y[7]) && (e.diff[7] != x[7]);
      return e;
   endfunction

   // Advance past the next rising edge and settle before sampling.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic bi);
      m_a     = x;
      m_b     = y;
      m_bin   = bi;
      m_start = 1'b1;
      sb_main.push_back(model8(x, y, bi));
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      checks++;
      if ({m_busy, m_done, m_bout, m_ovf} !== 4'b0000 || m_diff !== 8'h00) begin
         errors++;
         $display("FAIL reset_main: busy=%b done=%b diff=%h bout=%b ovf=%b, required all zero",
                  m_busy, m_done, m_diff, m_bout, m_ovf);
      end
      checks++;
      if ({w_busy, w_done, w_diff, w_bout, w_ovf} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_w1: busy=%b done=%b diff=%b bout=%b ovf=%b, required all zero",
                  w_busy, w_done, w_diff, w_bout, w_ovf);
      end
      rst = 1'b0;
      tick;
      tick;
      checks++;
      if (m_busy !== 1'b0 || m_done !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start: busy=%b done=%b, required 0 0", m_busy, m_done);
      end
   endtask

   task automatic test_basic;
      logic [7:0] va[10];
      logic [7:0] vb[10];
      logic       vc[10];
      logic [7:0] prev;
      exp_t       e;
      va = '{8'h05, 8'h03, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      vb = '{8'h03, 8'h05, 8'h01, 8'h00, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
      vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int k = 6; k < 10; k++) begin
         va[k] = 8'($urandom);
         vb[k] = 8'($urandom);
         vc[k] = 1'($urandom);
      end
      for (int n = 0; n < 10; n++) begin
         prev = m_diff;
         launch(va[n], vb[n], vc[n]);
         tick;
         m_start = 1'b0;
         m_a     = 8'($urandom);
         m_b     = 8'($urandom);
         for (int j = 0; j < W; j++) begin
            checks++;
            if (m_busy !== 1'b1 || m_done !== 1'b0) begin
               errors++;
               $display("FAIL basic_busy op%0d cyc%0d: busy=%b done=%b, required busy=1 done=0",
                        n, j, m_busy, m_done);
            end
            checks++;
            if (m_diff !== prev) begin
               errors++;
               $display("FAIL basic_hold op%0d cyc%0d: diff=%h, required %h", n, j, m_diff, prev);
            end
            tick;
         end
         checks++;
         if (m_done !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done op%0d: done=%b busy=%b, required done=1 busy=0",
                     n, m_done, m_busy);
         end
         e = sb_main.pop_front();
         checks++;
         if (m_diff !== e.diff[7:0] || m_bout !== e.bout || m_ovf !== e.ovf) begin
            errors++;
            $display("FAIL basic_result op%0d %h-%h-%b: diff=%h bout=%b ovf=%b, required diff=%h bout=%b ovf=%b",
                     n, va[n], vb[n], vc[n], m_diff, m_bout, m_ovf, e.diff[7:0], e.bout, e.ovf);
         end
         tick;
         checks++;
         if (m_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse op%0d: done=%b one cycle later, required 0", n, m_done);
         end
      end
   endtask

   task automatic test_back_to_back;
      int   n_done = 0;
      exp_t e;
      m_start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         m_a   = 8'(i * 37 + 11);
         m_b   = 8'($urandom);
         m_bin = 1'($urandom);
         if (i % 10 == 0) sb_main.push_back(model8(m_a, m_b, m_bin));
         tick;
         checks++;
         if (m_done !== ((i % 10) == 8)) begin
            errors++;
            $display("FAIL b2b_cadence cyc%0d: done=%b, required %b", i, m_done, ((i % 10) == 8));
         end
         if (m_done === 1'b1) begin
            n_done++;
            checks++;
            if (sb_main.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_done cyc%0d: done=1, required no pending op", i);
            end else begin
               e = sb_main.pop_front();
               if (m_diff !== e.diff[7:0] || m_bout !== e.bout || m_ovf !== e.ovf) begin
                  errors++;
                  $display("FAIL b2b_result cyc%0d: diff=%h bout=%b ovf=%b, required diff=%h bout=%b ovf=%b",
                           i, m_diff, m_bout, m_ovf, e.diff[7:0], e.bout, e.ovf);
               end
            end
         end
      end
      m_start = 1'b0;
      tick;
      tick;
      checks++;
      if (n_done != 4 || sb_main.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: dones=%0d pending=%0d, required dones=4 pending=0",
                  n_done, sb_main.size());
      end
   endtask

   task automatic test_reset_abort;
      int   t;
      int   seen;
      exp_t e;
      launch(8'h55, 8'h11, 1'b0);
      tick;
      m_start = 1'b0;
      tick;
      tick;
      tick;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({m_busy, m_done, m_bout, m_ovf} !== 4'b0000 || m_diff !== 8'h00) begin
         errors++;
         $display("FAIL abort_async: busy=%b done=%b diff=%h bout=%b ovf=%b, required all zero",
                  m_busy, m_done, m_diff, m_bout, m_ovf);
      end
      tick;
      rst = 1'b0;
      sb_main.delete();
      seen = 0;
      for (int i = 0; i < 14; i++) begin
         tick;
         if (m_done === 1'b1 || m_busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_done: active cycles=%0d after abort, required 0", seen);
      end
      launch(8'h10, 8'h01, 1'b0);
      tick;
      m_start = 1'b0;
      t = 0;
      while (m_done !== 1'b1 && t < 30) begin
         tick;
         t++;
      end
      checks++;
      if (m_done !== 1'b1 || t != W) begin
         errors++;
         $display("FAIL abort_next_latency: done=%b after %0d cycles, required done=1 after %0d",
                  m_done, t, W);
      end
      e = sb_main.pop_front();
      checks++;
      if (m_diff !== e.diff[7:0] || m_diff !== 8'h0F || m_bout !== e.bout || m_ovf !== e.ovf) begin
         errors++;
         $display("FAIL abort_next_result: diff=%h bout=%b ovf=%b, required diff=0f bout=%b ovf=%b",
                  m_diff, m_bout, m_ovf, e.bout, e.ovf);
      end
      tick;
   endtask

   task automatic test_chain;
      logic [15:0] ca[3];
      logic [15:0] cb[3];
      int          r;
      int          t;
      exp_t        e;
      ca = '{16'h0100, 16'h0000, 16'h0000};
      cb = '{16'h0001, 16'h0000, 16'h0000};
      ca[1] = 16'($urandom);
      cb[1] = 16'($urandom);
      ca[2] = 16'h1234;
      cb[2] = 16'h1235;
      for (int k = 0; k < 3; k++) begin
         r      = int'(ca[k]) - int'(cb[k]);
         e.diff = r[15:0];
         e.bout = (r < 0);
         e.ovf  = 1'b0;
         sb_chain.push_back(e);
         l_a     = ca[k][7:0];
         l_b     = cb[k][7:0];
         l_bin   = 1'b0;
         l_start = 1'b1;
         tick;
         l_start = 1'b0;
         t = 0;
         while (l_done !== 1'b1 && t < 30) begin
            tick;
            t++;
         end
         checks++;
         if (l_done !== 1'b1) begin
            errors++;
            $display("FAIL chain_lo_timeout op%0d: done=%b, required 1 within 30 cycles", k, l_done);
         end
         h_a     = ca[k][15:8];
         h_b     = cb[k][15:8];
         h_start = 1'b1;
         tick;
         h_start = 1'b0;
         t = 0;
         while (h_done !== 1'b1 && t < 30) begin
            tick;
            t++;
         end
         checks++;
         if (h_done !== 1'b1) begin
            errors++;
            $display("FAIL chain_hi_timeout op%0d: done=%b, required 1 within 30 cycles", k, h_done);
         end
         e = sb_chain.pop_front();
         checks++;
         if ({h_diff, l_diff} !== e.diff || h_bout !== e.bout) begin
            errors++;
            $display("FAIL chain_result op%0d %h-%h: diff=%h bout=%b, required diff=%h bout=%b",
                     k, ca[k], cb[k], {h_diff, l_diff}, h_bout, e.diff, e.bout);
         end
         tick;
      end
   endtask

   task automatic test_width1;
      int   r;
      exp_t e;
      logic x, y, bi;
      for (int v = 0; v < 8; v++) begin
         x  = v[2];
         y  = v[1];
         bi = v[0];
         r      = int'(x) - int'(y) - int'(bi);
         e.diff = {15'h0000, r[0]};
         e.bout = (r < 0);
         e.ovf  = (x != y) && (r[0] != x);
         sb_w1.push_back(e);
         w_a     = x;
         w_b     = y;
         w_bin   = bi;
         w_start = 1'b1;
         tick;
         w_start = 1'b0;
         checks++;
         if (w_busy !== 1'b1 || w_done !== 1'b0) begin
            errors++;
            $display("FAIL w1_busy a=%b b=%b bin=%b: busy=%b done=%b, required busy=1 done=0",
                     x, y, bi, w_busy, w_done);
         end
         tick;
         checks++;
         if (w_done !== 1'b1 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL w1_done a=%b b=%b bin=%b: done=%b busy=%b, required done=1 busy=0",
                     x, y, bi, w_done, w_busy);
         end
         e = sb_w1.pop_front();
         checks++;
         if (w_diff !== e.diff[0:0] || w_bout !== e.bout || w_ovf !== e.ovf) begin
            errors++;
            $display("FAIL w1_result a=%b b=%b bin=%b: diff=%b bout=%b ovf=%b, required diff=%b bout=%b ovf=%b",
                     x, y, bi, w_diff, w_bout, w_ovf, e.diff[0], e.bout, e.ovf);
         end
         tick;
         checks++;
         if (w_done !== 1'b0) begin
            errors++;
            $display("FAIL w1_pulse a=%b b=%b bin=%b: done=%b, required 0", x, y, bi, w_done);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_reset_abort;
      test_chain;
      test_width1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
